// File: rtl/instr_cache_l1_assoc_pkg.sv
// Shared types and geometry helpers for the set-associative L1 instruction cache.
package icache_pkg;
    localparam int WORD_BITS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic int calc_off_w(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int sets, input int line_bits);
        return addr_w - calc_idx_w(sets) - calc_off_w(line_bits);
    endfunction
endpackage

// File: rtl/instr_cache_l1_assoc_if.sv
// Line-fill port between the L1 instruction cache (master) and L2/memory (slave).
interface icache_mem_if #(
    parameter int ADDR_W    = 32,
    parameter int LINE_BITS = 256
);
    logic                 mem_req;
    logic [ADDR_W-1:0]    mem_address;
    logic [LINE_BITS-1:0] mem_data;
    logic                 mem_valid;

    modport master (output mem_req, output mem_address, input mem_data, input mem_valid);
    modport slave  (input mem_req, input mem_address, output mem_data, output mem_valid);
endinterface

// File: rtl/instr_cache_l1_assoc_plru.sv
// Per-set tree pseudo-LRU: WAYS-1 direction bits per set, each pointing toward the victim half.
module icache_plru #(
    parameter int WAYS = 2,
    parameter int SETS = 512,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx,
    input  logic [WAY_W-1:0] access_way,
    input  logic             update,
    output logic [WAY_W-1:0] victim
);
    generate
        if (WAYS == 1) begin : g_direct
            logic unused_in;
            assign unused_in = ^{clk, rst, idx, access_way, update};
            assign victim = '0;
        end else begin : g_tree
            localparam int NODES = WAYS - 1;
            localparam int LVLS  = $clog2(WAYS);

            logic [NODES-1:0] tree_q [SETS];
            logic [NODES-1:0] tree_cur;
            logic [NODES-1:0] tree_upd;

            assign tree_cur = tree_q[idx];

            always_comb begin
                int               node;
                logic [NODES-1:0] sh;
                node = 0;
                for (int l = 0; l < LVLS; l++) begin
                    sh   = tree_cur >> node;
                    node = 2 * node + 1 + int'(sh[0]);
                end
                victim = WAY_W'(node - NODES);
            end

            // Walk root-to-leaf along the accessed way, pointing every node away from it.
            always_comb begin
                int               node;
                logic [WAY_W-1:0] sw;
                logic             dir;
                tree_upd = tree_cur;
                node     = 0;
                for (int l = 0; l < LVLS; l++) begin
                    sw       = access_way >> (LVLS - 1 - l);
                    dir      = sw[0];
                    tree_upd = (tree_upd & ~(NODES'(1) << node)) | (NODES'(!dir) << node);
                    node     = 2 * node + 1 + int'(dir);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
                end else if (update) begin
                    tree_q[idx] <= tree_upd;
                end
            end
        end
    endgenerate
endmodule

// File: rtl/instr_cache_l1_assoc.sv
// N-way set-associative L1 instruction cache with PLRU replacement, req/valid line fill and flush.
// state | meaning
// IDLE  | lookup; launch fill on miss, start flush on request
// WAIT  | fill outstanding; request held until mem_valid
// FLUSH | invalidate one set per cycle, set 0 upward
module instr_cache_l1_assoc
    import icache_pkg::*;
#(
    parameter int WAYS      = 2,
    parameter int SETS      = 512,
    parameter int LINE_BITS = 256,
    parameter int ADDR_W    = 32
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [ADDR_W-1:0]    instr_addressIF,
    input  logic                 flush,
    output logic [WORD_BITS-1:0] instr_out,
    output logic                 hit,
    output logic                 stall,
    icache_mem_if.master         mem
);
    localparam int OFF_W  = calc_off_w(LINE_BITS);
    localparam int IDX_W  = calc_idx_w(SETS);
    localparam int TAG_W  = calc_tag_w(ADDR_W, SETS, LINE_BITS);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WSEL_W = OFF_W - 2;

    state_t state_q, state_d;
    logic [IDX_W-1:0]  lat_idx_q, lat_idx_d, flush_cnt_q, flush_cnt_d;
    logic [TAG_W-1:0]  lat_tag_q, lat_tag_d;
    logic              req_q, req_d, fpend_q, fpend_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;

    logic [LINE_BITS-1:0] data_q  [WAYS][SETS];
    logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
    logic [SETS-1:0]      valid_q [WAYS];

    logic [IDX_W-1:0]     idx, plru_idx;
    logic [TAG_W-1:0]     tag;
    logic [WSEL_W-1:0]    wsel;
    logic [WAYS-1:0]      match;
    logic                 hit_any, fill_en, plru_upd;
    logic [WAY_W-1:0]     hit_way, fill_way, plru_way, plru_victim;
    logic [LINE_BITS-1:0] line_sel, line_shift;
    logic                 unused_addr;

    assign idx  = instr_addressIF[OFF_W+IDX_W-1:OFF_W];
    assign tag  = instr_addressIF[ADDR_W-1:OFF_W+IDX_W];
    assign wsel = instr_addressIF[OFF_W-1:2];
    assign unused_addr = ^instr_addressIF[1:0];

    // Descending scan so the lowest matching way wins if tags ever alias.
    always_comb begin
        match    = '0;
        hit_way  = '0;
        line_sel = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
                match[w] = 1'b1;
                hit_way  = WAY_W'(w);
                line_sel = data_q[w][idx];
            end
        end
    end

    assign hit_any    = |match;
    assign hit        = hit_any && (state_q != FLUSH);
    assign stall      = !hit || (state_q != IDLE);
    assign line_shift = line_sel << (WORD_BITS * int'(wsel));
    assign instr_out  = hit ? line_shift[LINE_BITS-1 -: WORD_BITS] : '0;

    always_comb begin
        logic found;
        found    = 1'b0;
        fill_way = plru_victim;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[w][lat_idx_q]) begin
                fill_way = WAY_W'(w);
                found    = 1'b1;
            end
        end
    end

    assign plru_idx = (state_q == WAIT) ? lat_idx_q : idx;

    icache_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
        .clk        (CLK),
        .rst        (RESET),
        .idx        (plru_idx),
        .access_way (plru_way),
        .update     (plru_upd),
        .victim     (plru_victim)
    );

    always_comb begin
        state_d     = state_q;
        lat_idx_d   = lat_idx_q;
        lat_tag_d   = lat_tag_q;
        req_d       = req_q;
        maddr_d     = maddr_q;
        fpend_d     = fpend_q;
        flush_cnt_d = flush_cnt_q;
        fill_en     = 1'b0;
        plru_upd    = 1'b0;
        plru_way    = hit_way;
        case (state_q)
            IDLE: begin
                if (flush || fpend_q) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end else if (!hit_any) begin
                    lat_idx_d = idx;
                    lat_tag_d = tag;
                    req_d     = 1'b1;
                    maddr_d   = {instr_addressIF[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    state_d   = WAIT;
                end else begin
                    plru_upd = 1'b1;
                end
            end
            WAIT: begin
                if (flush) fpend_d = 1'b1;
                if (mem.mem_valid) begin
                    fill_en  = 1'b1;
                    plru_upd = 1'b1;
                    plru_way = fill_way;
                    req_d    = 1'b0;
                    maddr_d  = '0;
                    state_d  = IDLE;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = IDLE;
                    fpend_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            lat_idx_q   <= '0;
            lat_tag_q   <= '0;
            req_q       <= 1'b0;
            maddr_q     <= '0;
            fpend_q     <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_idx_q   <= lat_idx_d;
            lat_tag_q   <= lat_tag_d;
            req_q       <= req_d;
            maddr_q     <= maddr_d;
            fpend_q     <= fpend_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
        end else if (state_q == FLUSH) begin
            for (int w = 0; w < WAYS; w++) valid_q[w][flush_cnt_q] <= 1'b0;
        end else if (fill_en) begin
            valid_q[fill_way][lat_idx_q] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            data_q[fill_way][lat_idx_q] <= mem.mem_data;
            tag_q[fill_way][lat_idx_q]  <= lat_tag_q;
        end
    end

    assign mem.mem_req     = req_q;
    assign mem.mem_address = maddr_q;
endmodule

// File: tb/tb_instr_cache_l1_assoc.sv
// Directed bench for instr_cache_l1_assoc: table of hit lookups plus hand sequences for fill, eviction, flush and reset.
module tb_instr_cache_l1_assoc;
    localparam int WAYS      = 2;
    localparam int SETS      = 512;
    localparam int LINE_BITS = 256;
    localparam int ADDR_W    = 32;

    typedef struct {
        logic [31:0] addr;
        logic        exp_hit;
        logic [31:0] exp_instr;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] instr_addressIF = '0;
    logic        flush = 1'b0;
    logic [31:0] instr_out;
    logic        hit;
    logic        stall;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [LINE_BITS-1:0] line;
    logic [31:0]          alt [4];
    vec_t                 tbl [8];

    icache_mem_if #(.ADDR_W(ADDR_W), .LINE_BITS(LINE_BITS)) mem_bus ();

    instr_cache_l1_assoc #(
        .WAYS(WAYS), .SETS(SETS), .LINE_BITS(LINE_BITS), .ADDR_W(ADDR_W)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .instr_addressIF (instr_addressIF),
        .flush           (flush),
        .instr_out       (instr_out),
        .hit             (hit),
        .stall           (stall),
        .mem             (mem_bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_BITS-1:0] mk_line(input logic [15:0] seed);
        logic [LINE_BITS-1:0] l;
        for (int k = 0; k < 8; k++) l[LINE_BITS-1-32*k -: 32] = {seed, 16'(k)};
        return l;
    endfunction

    // Called at a falling edge; presents a missing address, serves the fill after lat cycles.
    task automatic do_fill(input logic [31:0] addr, input logic [LINE_BITS-1:0] data, input int lat);
        instr_addressIF = addr;
        #1;
        chk("miss_hit", 32'(hit), 32'd0);
        chk("miss_stall", 32'(stall), 32'd1);
        @(negedge CLK);
        chk("req_rise", 32'(mem_bus.mem_req), 32'd1);
        chk("req_addr", mem_bus.mem_address, addr & 32'hFFFF_FFE0);
        repeat (lat) @(negedge CLK);
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_data  = data;
        @(negedge CLK);
        mem_bus.mem_valid = 1'b0;
        mem_bus.mem_data  = '0;
        chk("req_drop", 32'(mem_bus.mem_req), 32'd0);
        chk("addr_drop", mem_bus.mem_address, 32'd0);
        #1;
        chk("fill_hit", 32'(hit), 32'd1);
    endtask

    task automatic look(input string name, input logic [31:0] addr, input logic exp_hit,
                        input logic [31:0] exp_instr);
        instr_addressIF = addr;
        #1;
        chk({name, "_hit"}, 32'(hit), 32'(exp_hit));
        chk({name, "_instr"}, instr_out, exp_instr);
        chk({name, "_stall"}, 32'(stall), 32'(!exp_hit));
        @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_bus.mem_valid = 1'b0;
        mem_bus.mem_data  = '0;
        alt[0] = 32'h0000_8060;
        alt[1] = 32'h0000_1234;
        alt[2] = 32'h0000_FFE0;
        alt[3] = 32'h0000_8060;

        tbl[0] = '{32'h0000_0048, 1'b1, 32'hDEAD_BEEF};
        tbl[1] = '{32'h0000_0040, 1'b1, 32'h0040_0000};
        tbl[2] = '{32'h0000_005C, 1'b1, 32'h0040_0007};
        tbl[3] = '{32'h0000_0000, 1'b1, 32'hA000_0000};
        tbl[4] = '{32'h0000_001C, 1'b1, 32'hA000_0007};
        tbl[5] = '{32'h0000_0044, 1'b1, 32'h0040_0001};
        tbl[6] = '{32'h0000_8004, 1'b1, 32'hA800_0001};
        tbl[7] = '{32'h0000_8010, 1'b1, 32'hA800_0004};

        repeat (3) @(negedge CLK);
        chk("rst_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst_addr", mem_bus.mem_address, 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        RESET = 1'b0;

        line = mk_line(16'h0040);
        line[LINE_BITS-1-64 -: 32] = 32'hDEAD_BEEF;
        do_fill(32'h0000_0040, line, 4);
        look("word2", 32'h0000_0048, 1'b1, 32'hDEAD_BEEF);

        // Two-way replacement in set 0.
        do_fill(32'h0000_0000, mk_line(16'hA000), 2);
        do_fill(32'h0000_4000, mk_line(16'hA400), 2);
        look("touch0", 32'h0000_0000, 1'b1, 32'hA000_0000);
        do_fill(32'h0000_8000, mk_line(16'hA800), 2);

        for (int i = 0; i < 8; i++) look($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp_hit, tbl[i].exp_instr);

        // 0x4000 was evicted; its refill takes way 0 (0x0), so 0x0 misses next.
        do_fill(32'h0000_4000, mk_line(16'hA401), 1);
        do_fill(32'h0000_0000, mk_line(16'hA000), 1);

        // Address wander during WAIT.
        instr_addressIF = 32'h0000_0060;
        #1;
        chk("wander_miss", 32'(hit), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("wander_addr", mem_bus.mem_address, 32'h0000_0060);
            instr_addressIF = alt[i];
        end
        @(negedge CLK);
        chk("wander_addr_last", mem_bus.mem_address, 32'h0000_0060);
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_data  = mk_line(16'h0060);
        @(negedge CLK);
        mem_bus.mem_valid = 1'b0;
        #1;
        chk("wander_other_tag", 32'(hit), 32'd0);
        instr_addressIF = 32'h0000_0060;
        #1;
        chk("wander_orig_hit", 32'(hit), 32'd1);
        @(negedge CLK);
        look("wander_w1", 32'h0000_0064, 1'b1, 32'h0060_0001);

        // Stray mem_valid in IDLE.
        instr_addressIF   = 32'h0000_0048;
        mem_bus.mem_valid = 1'b1;
        for (int k = 0; k < 8; k++) mem_bus.mem_data[32*k +: 32] = $urandom;
        @(negedge CLK);
        mem_bus.mem_valid = 1'b0;
        chk("stray_req", 32'(mem_bus.mem_req), 32'd0);
        look("stray_48", 32'h0000_0048, 1'b1, 32'hDEAD_BEEF);
        look("stray_60", 32'h0000_0060, 1'b1, 32'h0060_0000);
        look("stray_4000", 32'h0000_4000, 1'b1, 32'hA401_0000);

        // Flush while a fill is outstanding.
        instr_addressIF = 32'h0000_0080;
        #1;
        chk("fw_miss", 32'(hit), 32'd0);
        @(negedge CLK);
        chk("fw_req", 32'(mem_bus.mem_req), 32'd1);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        @(negedge CLK);
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_data  = mk_line(16'h0080);
        @(negedge CLK);
        mem_bus.mem_valid = 1'b0;
        chk("fw_req_drop", 32'(mem_bus.mem_req), 32'd0);
        #1;
        chk("fw_fill_hit", 32'(hit), 32'd1);
        chk("fw_fill_stall", 32'(stall), 32'd0);
        @(negedge CLK);
        chk("flush_first_hit", 32'(hit), 32'd0);
        chk("flush_first_stall", 32'(stall), 32'd1);
        @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        repeat (SETS - 3) @(negedge CLK);
        chk("flush_last_hit", 32'(hit), 32'd0);
        chk("flush_last_stall", 32'(stall), 32'd1);
        @(negedge CLK);
        chk("post_flush_req", 32'(mem_bus.mem_req), 32'd0);
        do_fill(32'h0000_0080, mk_line(16'h0081), 2);
        do_fill(32'h0000_4000, mk_line(16'hA402), 1);

        // Reset in the middle of a fill.
        instr_addressIF = 32'h0000_0040;
        #1;
        chk("rw_miss", 32'(hit), 32'd0);
        @(negedge CLK);
        chk("rw_req", 32'(mem_bus.mem_req), 32'd1);
        chk("rw_addr", mem_bus.mem_address, 32'h0000_0040);
        #2;
        RESET = 1'b1;
        #1;
        chk("rw_async_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rw_async_addr", mem_bus.mem_address, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_data  = mk_line(16'h0BAD);
        #1;
        chk("rw_post_miss", 32'(hit), 32'd0);
        @(negedge CLK);
        mem_bus.mem_valid = 1'b0;
        chk("rw_late_ignored", 32'(hit), 32'd0);
        chk("rw_new_req", 32'(mem_bus.mem_req), 32'd1);
        mem_bus.mem_valid = 1'b1;
        mem_bus.mem_data  = mk_line(16'h0041);
        @(negedge CLK);
        mem_bus.mem_valid = 1'b0;
        look("rw_refill", 32'h0000_0040, 1'b1, 32'h0041_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/instr_cache_l1_assoc.md
Name: instr_cache_l1_assoc

Overview:
- Parametrised, N-way set-associative L1 instruction cache; successor to the direct-mapped L1 I-cache.
- Sits between the IF stage and the L2/memory line port.
- Returns a 32-bit instruction combinationally on hit; on miss, runs a proper request/valid line-fill handshake instead of a fixed-latency counter.
- Adds configurable associativity, pseudo-LRU replacement, a flush operation and an explicit stall output.

Parameters:
- WAYS, 2, associativity; power of 2, 1..8.
- SETS, 512, sets per way; power of 2.
- LINE_BITS, 256, line width in bits; power of 2, at least 64.
- ADDR_W, 32, byte address width.
- Derived: OFF_W = log2(LINE_BITS/8); IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W - OFF_W.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- instr_addressIF  in  ADDR_W  fetch byte address.
- flush  in  1  one-cycle pulse; invalidate all lines.
- instr_out  out  32  selected instruction word.
- hit  out  1  valid tag match in any way; forced 0 while FLUSH is active.
- stall  out  1  equals (~hit) or (state != IDLE).
- mem_req  out  1  line-fill request; held high until mem_valid.
- mem_address  out  ADDR_W  line-aligned fill address.
- mem_data  in  LINE_BITS  fill data; valid only when mem_valid=1.
- mem_valid  in  1  one-cycle pulse accompanying mem_data.

Behaviour:
- Reset (async, RESET=1):
  - All valid bits = 0 and all PLRU bits = 0.
  - State = IDLE; mem_req = 0; mem_address = 0; flush_pending = 0.
  - The data/tag arrays themselves are not reset.
- Lookup (combinational):
  - Index = addr[OFF_W+IDX_W-1:OFF_W]; tag = addr[ADDR_W-1:OFF_W+IDX_W].
  - hit = OR over all ways of (valid & tag match).
  - instr_out = word addr[OFF_W-1:2] of the hitting line. Word 0 occupies the MSBs (bits LINE_BITS-1 : LINE_BITS-32).
  - instr_out is don't-care when hit=0; drive 0.
- State IDLE:
  - If flush or flush_pending is set, go to FLUSH (flush has priority over a miss).
  - Else, on miss: latch index and tag, set mem_req=1, mem_address = {addr[ADDR_W-1:OFF_W], OFF_W zeros}, go to WAIT.
  - Else, on hit: update the set's PLRU bits toward the hitting way.
- State WAIT:
  - mem_req and mem_address are held stable; instr_addressIF changes are ignored.
  - When mem_valid=1, on the same edge:
    - write mem_data, the latched tag and valid=1 into the victim way at the latched index;
    - update PLRU toward that way;
    - mem_req <= 0, mem_address <= 0;
    - go to IDLE.
  - flush arriving in WAIT sets flush_pending; the fill completes first.
- Victim selection: lowest-numbered invalid way; if all ways are valid, the tree-PLRU victim. WAYS=1 always selects way 0.
- State FLUSH:
  - Clears the valid bits of one set per cycle, starting at set 0.
  - Returns to IDLE after SETS cycles; clears flush_pending.
  - A flush pulse during FLUSH is absorbed.
- Latency:
  - Miss detected in cycle 0; mem_req rises at edge 1.
  - mem_valid in cycle N writes the line at edge N+1.
  - hit=1 for the same address in cycle N+1, giving a minimum miss penalty of 2 cycles.
- mem_valid outside WAIT is ignored (no array write). Reset in mid-WAIT drops the request immediately; a late mem_valid is then ignored.
- The array holds a single write port and one combinational read per cycle.

Decomposition:
- Package icache_pkg:
  - state enum {IDLE, WAIT, FLUSH};
  - functions for the OFF_W/IDX_W/TAG_W derivations;
  - constant WORD_BITS=32.
- Sub-module icache_plru, parameters WAYS and SETS:
  - holds per-set tree bits (WAYS-1 per set), async reset to 0;
  - inputs: set index, access-way plus update strobe;
  - output: victim way for the set.

Test Plan:
- Reset, then fetch 0x0000_0040 -> hit=0, stall=1; mem_req=1 with mem_address=0x40 one cycle later; mem_valid after 5 cycles with data word2=0xDEADBEEF -> mem_req=0 at the fill edge; next cycle hit=1 and instr_out for 0x48 = 0xDEADBEEF.
- WAYS=2: fill 0x0000_0000, then 0x0000_4000 (same set, different tag), then touch 0x0 -> hit; then 0x0000_8000 misses and evicts 0x4000. Refetch 0x0 -> hit=1; 0x4000 -> hit=0.
- Change instr_addressIF every cycle during WAIT -> mem_address stays constant; the line is filled at the originally latched index and tag only.
- Pulse flush while in WAIT -> fill completes, then FLUSH runs SETS cycles with hit=0 and stall=1; afterwards every earlier address misses.
- Assert mem_valid in IDLE with random data -> no change; previously cached lines still return their original words.
- Assert RESET mid-WAIT -> mem_req=0 and mem_address=0 immediately (asynchronously); a following mem_valid is ignored; the first fetch after release misses.
